// File: rtl/cpu_isa_pkg.sv
// Shared CSE-BUBBLE ISA definitions: field positions, opcode/funct encodings,
// instruction IDs and the decoded-payload struct used by decode, control and ALU.
package cpu_isa_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;

  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned S_LSB   = 21;
  localparam int unsigned T_LSB   = 16;
  localparam int unsigned D_LSB   = 11;
  localparam int unsigned SH_LSB  = 6;
  localparam int unsigned FN_LSB  = 0;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000001;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [OP_W-1:0] FN_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] FN_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] FN_ADDU = 6'b000010;
  localparam logic [OP_W-1:0] FN_SUBU = 6'b000011;
  localparam logic [OP_W-1:0] FN_AND  = 6'b000100;
  localparam logic [OP_W-1:0] FN_OR   = 6'b000101;
  localparam logic [OP_W-1:0] FN_SLL  = 6'b000110;
  localparam logic [OP_W-1:0] FN_SRL  = 6'b000111;
  localparam logic [OP_W-1:0] FN_SLT  = 6'b001000;
  localparam logic [OP_W-1:0] FN_JR   = 6'b001001;

  typedef enum logic [4:0] {
    ID_ILLEGAL = 5'd0,
    ID_ADD     = 5'd1,
    ID_SUB     = 5'd2,
    ID_ADDU    = 5'd3,
    ID_SUBU    = 5'd4,
    ID_AND     = 5'd5,
    ID_OR      = 5'd6,
    ID_SLL     = 5'd7,
    ID_SRL     = 5'd8,
    ID_SLT     = 5'd9,
    ID_JR      = 5'd10,
    ID_ADDI    = 5'd11,
    ID_ADDIU   = 5'd12,
    ID_ANDI    = 5'd13,
    ID_ORI     = 5'd14,
    ID_LW      = 5'd15,
    ID_SW      = 5'd16,
    ID_BEQ     = 5'd17,
    ID_BNE     = 5'd18,
    ID_SLTI    = 5'd19,
    ID_J       = 5'd20,
    ID_JAL     = 5'd21
  } instr_id_e;

  typedef struct packed {
    logic [XLEN-1:0] id;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic [XLEN-1:0] rd;
    logic            illegal;
  } decode_t;

  function automatic logic [OP_W-1:0] f_op(input logic [XLEN-1:0] ir);
    return ir[OP_LSB +: OP_W];
  endfunction

  function automatic logic [XLEN-1:0] f_reg(input logic [XLEN-1:0] ir, input int unsigned lsb);
    return XLEN'(ir[lsb +: REG_W]);
  endfunction

  function automatic logic [XLEN-1:0] f_id(input instr_id_e id);
    return XLEN'(id);
  endfunction

endpackage

// File: rtl/instr_decode_if.sv
// Instruction-in / decoded-operands-out bundle between the IR and the decoder.
interface instr_decode_if;
  import cpu_isa_pkg::*;

  logic            in_valid;
  logic [XLEN-1:0] ir;
  logic            out_valid;
  logic [XLEN-1:0] ID;
  logic [XLEN-1:0] rs;
  logic [XLEN-1:0] rt;
  logic [XLEN-1:0] rd;
  logic            illegal;

  modport master (
    output in_valid, ir,
    input  out_valid, ID, rs, rt, rd, illegal
  );

  modport slave (
    input  in_valid, ir,
    output out_valid, ID, rs, rt, rd, illegal
  );

endinterface

// File: rtl/instr_decode_comb.sv
// Purely combinational decode of one instruction word into ID/operands/illegal.
module instr_decode_comb
  import cpu_isa_pkg::*;
(
  input  logic [XLEN-1:0] ir_i,
  output decode_t         dec_o
);

  logic [OP_W-1:0]  op;
  logic [OP_W-1:0]  fn;
  logic [XLEN-1:0]  s_ext;
  logic [XLEN-1:0]  t_ext;
  logic [XLEN-1:0]  d_ext;
  logic [XLEN-1:0]  sh_ext;
  logic [XLEN-1:0]  imm_sx;
  logic [XLEN-1:0]  imm_zx;
  logic [XLEN-1:0]  tgt_zx;

  assign op     = f_op(ir_i);
  assign fn     = ir_i[FN_LSB +: OP_W];
  assign s_ext  = f_reg(ir_i, S_LSB);
  assign t_ext  = f_reg(ir_i, T_LSB);
  assign d_ext  = f_reg(ir_i, D_LSB);
  assign sh_ext = f_reg(ir_i, SH_LSB);
  assign imm_sx = {{(XLEN-IMM_W){ir_i[IMM_W-1]}}, ir_i[IMM_W-1:0]};
  assign imm_zx = XLEN'(ir_i[IMM_W-1:0]);
  assign tgt_zx = XLEN'(ir_i[TGT_W-1:0]);

  always_comb begin
    dec_o = '0;
    unique case (op)
      OP_RTYPE: begin
        dec_o.rs = s_ext;
        dec_o.rt = t_ext;
        dec_o.rd = d_ext;
        unique case (fn)
          FN_ADD:  dec_o.id = f_id(ID_ADD);
          FN_SUB:  dec_o.id = f_id(ID_SUB);
          FN_ADDU: dec_o.id = f_id(ID_ADDU);
          FN_SUBU: dec_o.id = f_id(ID_SUBU);
          FN_AND:  dec_o.id = f_id(ID_AND);
          FN_OR:   dec_o.id = f_id(ID_OR);
          FN_SLL: begin
            dec_o.id = f_id(ID_SLL);
            dec_o.rs = sh_ext;
          end
          FN_SRL: begin
            dec_o.id = f_id(ID_SRL);
            dec_o.rs = sh_ext;
          end
          FN_SLT:  dec_o.id = f_id(ID_SLT);
          FN_JR: begin
            dec_o.id = f_id(ID_JR);
            dec_o.rt = '0;
            dec_o.rd = '0;
          end
          default: dec_o = '{id: '0, rs: '0, rt: '0, rd: '0, illegal: 1'b1};
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_SLTI: begin
        dec_o.rs = s_ext;
        dec_o.rt = t_ext;
        dec_o.rd = imm_sx;
        unique case (op)
          OP_ADDI:  dec_o.id = f_id(ID_ADDI);
          OP_ADDIU: dec_o.id = f_id(ID_ADDIU);
          OP_ANDI: begin
            dec_o.id = f_id(ID_ANDI);
            dec_o.rd = imm_zx;
          end
          OP_ORI: begin
            dec_o.id = f_id(ID_ORI);
            dec_o.rd = imm_zx;
          end
          OP_LW:    dec_o.id = f_id(ID_LW);
          OP_SW:    dec_o.id = f_id(ID_SW);
          OP_BEQ:   dec_o.id = f_id(ID_BEQ);
          OP_BNE:   dec_o.id = f_id(ID_BNE);
          default:  dec_o.id = f_id(ID_SLTI);
        endcase
      end
      OP_J: begin
        dec_o.id = f_id(ID_J);
        dec_o.rd = tgt_zx;
      end
      OP_JAL: begin
        dec_o.id = f_id(ID_JAL);
        dec_o.rd = tgt_zx;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode.sv
// Registered instruction decoder: one-cycle latency, results hold while in_valid is low.
module instr_decode
  import cpu_isa_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  instr_decode_if.slave  bus
);

  decode_t dec_c;
  decode_t dec_d;
  decode_t dec_q;
  logic    valid_d;
  logic    valid_q;

  instr_decode_comb u_comb (
    .ir_i  (bus.ir),
    .dec_o (dec_c)
  );

  // Invalid cycles keep the last decoded result visible downstream.
  assign dec_d   = bus.in_valid ? dec_c : dec_q;
  assign valid_d = bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.ID        = dec_q.id;
  assign bus.rs        = dec_q.rs;
  assign bus.rt        = dec_q.rt;
  assign bus.rd        = dec_q.rd;
  assign bus.illegal   = dec_q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Directed self-checking bench for instr_decode with hand-computed expectations.
module tb_instr_decode;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  instr_decode_if bus ();

  instr_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] ir);
    rst          = r;
    bus.in_valid = v;
    bus.ir       = ir;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [31:0] id,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] rd, input logic ill);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".ID"},        bus.ID, id);
    chk({tag, ".rs"},        bus.rs, rs);
    chk({tag, ".rt"},        bus.rt, rt);
    chk({tag, ".rd"},        bus.rd, rd);
    chk({tag, ".illegal"},   32'(bus.illegal), 32'(ill));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.ir       = '0;
    #2;

    drive(1'b1, 1'b1, $urandom);
    expect_out("reset0", 1'b0, 0, 0, 0, 0, 1'b0);
    drive(1'b1, 1'b1, $urandom);
    expect_out("reset1", 1'b0, 0, 0, 0, 0, 1'b0);

    drive(1'b0, 1'b1, 32'h05EFFFC0);
    expect_out("add", 1'b1, 1, 15, 15, 31, 1'b0);
    drive(1'b0, 1'b1, 32'h05EFFFC1);
    expect_out("sub", 1'b1, 2, 15, 15, 31, 1'b0);
    drive(1'b0, 1'b1, 32'h05EFF946);
    expect_out("sll", 1'b1, 7, 5, 15, 31, 1'b0);
    drive(1'b0, 1'b1, 32'h05EFF947);
    expect_out("srl", 1'b1, 8, 5, 15, 31, 1'b0);
    drive(1'b0, 1'b1, 32'h05EFF809);
    expect_out("jr", 1'b1, 10, 15, 0, 0, 1'b0);

    drive(1'b0, 1'b1, 32'h24CF8000);
    expect_out("addiu", 1'b1, 12, 6, 15, 32'hFFFF8000, 1'b0);
    drive(1'b0, 1'b1, 32'h210F0000);
    expect_out("addi", 1'b1, 11, 8, 15, 0, 1'b0);
    drive(1'b0, 1'b1, 32'h34648000);
    expect_out("ori", 1'b1, 14, 3, 4, 32'h00008000, 1'b0);
    drive(1'b0, 1'b1, 32'h3064FFFF);
    expect_out("andi", 1'b1, 13, 3, 4, 32'h0000FFFF, 1'b0);
    drive(1'b0, 1'b1, 32'h1064FFFE);
    expect_out("beq", 1'b1, 17, 3, 4, 32'hFFFFFFFE, 1'b0);

    drive(1'b0, 1'b1, 32'h550F0000);
    expect_out("illegal_op", 1'b1, 0, 0, 0, 0, 1'b1);
    drive(1'b0, 1'b1, 32'h05EFFFFF);
    expect_out("illegal_fn", 1'b1, 0, 0, 0, 0, 1'b1);

    drive(1'b0, 1'b1, 32'h08ABCDEF);
    expect_out("j", 1'b1, 20, 0, 0, 32'h00ABCDEF, 1'b0);
    drive(1'b0, 1'b0, 32'h05EFFFC0);
    expect_out("hold0", 1'b0, 20, 0, 0, 32'h00ABCDEF, 1'b0);
    drive(1'b0, 1'b0, 32'h550F0000);
    expect_out("hold1", 1'b0, 20, 0, 0, 32'h00ABCDEF, 1'b0);

    drive(1'b0, 1'b1, 32'h0FFFFFFF);
    expect_out("jal", 1'b1, 21, 0, 0, 32'h03FFFFFF, 1'b0);
    drive(1'b0, 1'b1, 32'h8CC50004);
    expect_out("lw", 1'b1, 15, 6, 5, 4, 1'b0);
    drive(1'b0, 1'b1, 32'hACC5FFFC);
    expect_out("sw", 1'b1, 16, 6, 5, 32'hFFFFFFFC, 1'b0);
    drive(1'b0, 1'b1, 32'h14C50010);
    expect_out("bne", 1'b1, 18, 6, 5, 32'h00000010, 1'b0);
    drive(1'b0, 1'b1, 32'h28C58000);
    expect_out("slti", 1'b1, 19, 6, 5, 32'hFFFF8000, 1'b0);
    drive(1'b0, 1'b1, 32'h05EFFFC3);
    expect_out("subu", 1'b1, 4, 15, 15, 31, 1'b0);

    drive(1'b1, 1'b1, 32'h05EFFFC0);
    expect_out("midreset", 1'b0, 0, 0, 0, 0, 1'b0);
    drive(1'b0, 1'b1, 32'h05EFFFC5);
    expect_out("or_after_reset", 1'b1, 6, 15, 15, 31, 1'b0);
    drive(1'b0, 1'b1, 32'h05EFFFC8);
    expect_out("slt", 1'b1, 9, 15, 15, 31, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
# instr_decode

Registered instruction decoder for the single-issue CSE-BUBBLE datapath. It sits between the instruction register and the register-file/ALU control. It takes a 32-bit instruction word and produces:
- a numeric instruction ID;
- three 32-bit operand parameters (register indices or extended immediates/targets);
- an illegal-opcode flag.

Results are registered one clock after the instruction is presented.

## Interface
- No parameters. Field positions and the opcode/ID table are fixed constants.
- clk  in  1  system clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ir is valid this cycle
- ir  in  32  instruction word
- out_valid  out  1  registered copy of in_valid
- ID  out  32  decoded instruction ID, zero-extended; 0 = illegal
- rs  out  32  parameter 1
- rt  out  32  parameter 2
- rd  out  32  parameter 3
- illegal  out  1  opcode/funct not in table

## Operation
- Fields:
  - op = ir[31:26], s = ir[25:21], t = ir[20:16], d = ir[15:11]
  - sh = ir[10:6], fn = ir[5:0]
  - imm = ir[15:0], tgt = ir[25:0]
- R-type, op=000001. ID selected by fn:
  - 000000 add=1, 000001 sub=2, 000010 addu=3, 000011 subu=4
  - 000100 and=5, 000101 or=6, 000110 sll=7, 000111 srl=8
  - 001000 slt=9, 001001 jr=10
- R-type parameters:
  - General: rs={27'b0,s}, rt={27'b0,t}, rd={27'b0,d}.
  - sll/srl: rs={27'b0,sh}; rt and rd as above.
  - jr: rt=0, rd=0.
- I-type opcodes:
  - 001000 addi=11, 001001 addiu=12, 001100 andi=13, 001101 ori=14
  - 100011 lw=15, 101011 sw=16, 000100 beq=17, 000101 bne=18, 001010 slti=19
- I-type parameters: rs={27'b0,s}, rt={27'b0,t}, rd=sign-extended imm.
  - Exception: andi/ori zero-extend imm.
- J-type opcodes: 000010 j=20, 000011 jal=21.
  - Parameters: rs=0, rt=0, rd={6'b0,tgt}.
- Any other op, including 010101, or any undefined fn under op=000001:
  - ID=0, rs=rt=rd=0, illegal=1.
- Decode is a pure function of ir. Unused ir bits do not affect outputs.

## Timing
- Latency 1 cycle. Values sampled at edge N with in_valid=1 appear after edge N.
- If in_valid=0 at an edge:
  - out_valid=0 next cycle.
  - ID, rs, rt, rd, illegal hold their previous values.
- Back-to-back valid instructions are decoded at full rate, one per cycle. There is no stall/backpressure.
- Reset (rst=1 at an edge): out_valid=0, ID=0, rs=rt=rd=0, illegal=0. This overrides in_valid.
- Reset asserted mid-stream discards the instruction sampled on that edge.
- First valid decode completes on the first edge after rst deasserts with in_valid=1.

## Structure
- Shared package `cpu_isa_pkg`:
  - opcode constants (OP_RTYPE, OP_ADDI, …)
  - funct constants
  - ID constants (ID_ILLEGAL=0 … ID_JAL=21)
  - field slice positions
- Also used by the control unit and ALU.
- One natural sub-module `instr_decode_comb`:
  - purely combinational ir → {ID, rs, rt, rd, illegal};
  - the top adds the valid/hold/reset register stage.

## Test plan
- Reset: hold rst=1 two cycles with in_valid=1, ir=random → all outputs 0 and out_valid=0 throughout.
- R-type add: ir=0x05EFFFC0 (op=000001, s=15, t=15, d=31, sh=31, fn=0) → next cycle ID=1, rs=15, rt=15, rd=31, illegal=0.
- R-type fn=000001, same fields → ID=2, rs=15, rt=15, rd=31. Check sll (fn=000110, sh=5) → ID=7, rs=5.
- I-type:
  - addiu ir=0x24CF8000 → ID=12, rs=6, rt=15, rd=0xFFFF8000.
  - addi ir=0x210F0000 → ID=11, rs=8, rt=15, rd=0.
  - ori with imm=0x8000 → rd=0x00008000.
- Illegal: op=010101 (ir=0x550F0000) → ID=0, rs=rt=rd=0, illegal=1. Undefined fn=111111 under op=000001 → same.
- Valid gating and J-type:
  - Drop in_valid for 2 cycles between instructions → out_valid low, outputs held, then resume back-to-back decode with no gap.
  - j ir=0x08ABCDEF → ID=20, rd=0x00ABCDEF.
